// File: rtl/fractran_pkg.sv
// Shared definitions for the FRACTRAN program sequencer and the core it feeds.
package fractran_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

    // Width of one encoded fraction; the core decodes the same width
    localparam int FRAC_W = 8;

    // Result encoding returned by the core on res_hit
    localparam logic RES_HIT  = 1'b1;
    localparam logic RES_MISS = 1'b0;

endpackage

// File: rtl/fractran_prog_mem.sv
// Program store: DEPTH x FRAC_W register file, one synchronous write port,
// one asynchronous read port. Contents are not reset.
module fractran_prog_mem
    import fractran_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FRAC_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [FRAC_W-1:0] rd_data
);

    logic [FRAC_W-1:0] mem [DEPTH];

    // Write one program byte per cycle when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fractran_prog_seq.sv
// FRACTRAN program sequencer: loads a program over a byte handshake, then
// presents fractions to the core, restarting at 0 after each applied
// fraction, advancing on a miss, and halting after a pass with no hits.
module fractran_prog_seq
    import fractran_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int STEPW = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [FRAC_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    output logic              frac_valid,
    output logic [FRAC_W-1:0] frac_data,
    input  logic              frac_ready,
    input  logic              res_valid,
    input  logic              res_hit,
    output logic [AW-1:0]     pc,
    output logic [STEPW-1:0]  steps,
    output logic              busy,
    output logic              halted
);

    localparam logic [AW:0]    LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  PC_ONE   = AW'(1);
    localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);

    seq_state_t        state;
    logic [AW:0]       len;

    logic              idle_like;
    logic              len_full;
    logic              wr_en;
    logic [AW:0]       len_after_wr;
    logic [AW:0]       len_m1;
    logic              last_pc;
    logic              steps_full;
    logic [AW-1:0]     rd_addr;
    logic [FRAC_W-1:0] rd_data;
    logic [FRAC_W-1:0] next_frac;

    // Program accepts writes only from IDLE or HALT, and never while clear wins
    always_comb begin
        idle_like    = (state == ST_IDLE) || (state == ST_HALT);
        len_full     = (len == LEN_MAX);
        load_ready   = ena && (state == ST_IDLE) && !len_full;
        wr_en        = ena && idle_like && !clear && load_valid && !len_full;
        len_after_wr = wr_en ? (len + LEN_ONE) : len;
        len_m1       = len - LEN_ONE;
        last_pc      = ({1'b0, pc} == len_m1);
        steps_full   = (steps == {STEPW{1'b1}});
    end

    // Address of the fraction that will be presented next: pc+1 after a miss,
    // otherwise entry 0 (start or hit)
    always_comb begin
        rd_addr = '0;
        if ((state == ST_WAIT) && res_valid && (res_hit != RES_HIT)) begin
            rd_addr = pc + PC_ONE;
        end
    end

    // A start in the same cycle as the first write must see the new byte,
    // which the memory has not yet captured
    always_comb begin
        next_frac = rd_data;
        if (wr_en && (len[AW-1:0] == rd_addr)) begin
            next_frac = load_data;
        end
    end

    fractran_prog_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (len[AW-1:0]),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            pc         <= '0;
            steps      <= '0;
            frac_valid <= 1'b0;
            frac_data  <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (clear) begin
                        len    <= '0;
                        state  <= ST_IDLE;
                        halted <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            len <= len_after_wr;
                        end
                        if (start) begin
                            pc    <= '0;
                            steps <= '0;
                            if (len_after_wr == '0) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                state      <= ST_RUN;
                                busy       <= 1'b1;
                                halted     <= 1'b0;
                                frac_valid <= 1'b1;
                                frac_data  <= next_frac;
                            end
                        end else if (load_valid) begin
                            state  <= ST_IDLE;
                            halted <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (frac_ready) begin
                        frac_valid <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (res_valid) begin
                        if (res_hit == RES_HIT) begin
                            if (!steps_full) begin
                                steps <= steps + STEP_ONE;
                            end
                            pc         <= '0;
                            state      <= ST_RUN;
                            frac_valid <= 1'b1;
                            frac_data  <= next_frac;
                        end else if (!last_pc) begin
                            pc         <= pc + PC_ONE;
                            state      <= ST_RUN;
                            frac_valid <= 1'b1;
                            frac_data  <= next_frac;
                        end else begin
                            state  <= ST_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    frac_valid <= 1'b0;
                    busy       <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fractran_prog_seq.sv
// Self-checking bench for fractran_prog_seq: a bench-side model of FRACTRAN
// control flow fills a scoreboard of expected (pc, fraction) visits, and a
// core responder pops and compares each presented fraction.
module tb_fractran_prog_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clear;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       start;
    logic       frac_valid;
    logic [7:0] frac_data;
    logic       frac_ready;
    logic       res_valid;
    logic       res_hit;
    logic [3:0] pc;
    logic [15:0] steps;
    logic       busy;
    logic       halted;

    typedef struct {
        int         pc;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] prog [16];
    int         n_compared;
    int         n_mismatched;
    int         exp_pc;
    int         exp_steps;
    logic       timed_out;

    fractran_prog_seq #(
        .DEPTH (16),
        .STEPW (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .frac_valid (frac_valid),
        .frac_data  (frac_data),
        .frac_ready (frac_ready),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .pc         (pc),
        .steps      (steps),
        .busy       (busy),
        .halted     (halted)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the design wedges outside any bounded wait
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst_n      = 1'b0;
        ena        = 1'b1;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        start      = 1'b0;
        frac_ready = 1'b0;
        res_valid  = 1'b0;
        res_hit    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyLoad(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic applyStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bench model of FRACTRAN control flow; core hits at hit_pc n_hits times
    task automatic buildExpected(input int n, input int hit_pc, input int n_hits,
                                 output int e_pc, output int e_steps);
        int p = 0;
        int h = n_hits;
        int s = 0;
        sb_q.delete();
        for (int k = 0; k < 1000; k++) begin
            sb_q.push_back('{p, prog[p]});
            if (p == hit_pc && h > 0) begin
                h--;
                s++;
                p = 0;
            end else if (p == n - 1) begin
                break;
            end else begin
                p++;
            end
        end
        e_pc    = p;
        e_steps = s;
    endtask

    // Core responder: accept each fraction, answer one cycle later
    task automatic applyCore(input int hit_pc, input int n_hits, output logic to);
        int   hits_left = n_hits;
        int   guard     = 0;
        exp_t e;
        to = 1'b0;
        while (!halted) begin
            if (guard > 3000) begin
                to = 1'b1;
                break;
            end
            guard++;
            if (frac_valid) begin
                checkOutput("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() == 0) break;
                e = sb_q.pop_front();
                checkOutput("frac_pc", 32'(pc), 32'(e.pc));
                checkOutput("frac_data", 32'(frac_data), 32'(e.data));
                frac_ready = 1'b1;
                @(negedge clk);
                frac_ready = 1'b0;
                checkOutput("wait_valid_low", 32'(frac_valid), 32'd0);
                @(negedge clk);
                res_valid = 1'b1;
                res_hit   = (e.pc == hit_pc) && (hits_left > 0);
                if (res_hit) hits_left--;
                @(negedge clk);
                res_valid = 1'b0;
                res_hit   = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic checkHalt(input string tag, input int e_pc, input int e_steps);
        checkOutput({tag, "_timeout"}, 32'(timed_out), 32'd0);
        checkOutput({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pc"}, 32'(pc), 32'(e_pc));
        checkOutput({tag, "_steps"}, 32'(steps), 32'(e_steps));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Reset values
        applyReset();
        checkOutput("rst_frac_valid", 32'(frac_valid), 32'd0);
        checkOutput("rst_frac_data", 32'(frac_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_steps", 32'(steps), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);

        // Three-entry program, core always misses
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        for (int i = 0; i < 3; i++) applyLoad(prog[i]);
        buildExpected(3, -1, 0, exp_pc, exp_steps);
        applyStart();
        checkOutput("t1_valid_after_start", 32'(frac_valid), 32'd1);
        applyCore(-1, 0, timed_out);
        checkHalt("t1", exp_pc, exp_steps);

        // Rerun from HALT, core hits at pc=1 twice
        buildExpected(3, 1, 2, exp_pc, exp_steps);
        applyStart();
        applyCore(1, 2, timed_out);
        checkHalt("t2", exp_pc, exp_steps);

        // Clear from HALT, then start with an empty program
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_halted", 32'(halted), 32'd0);
        checkOutput("clr_load_ready", 32'(load_ready), 32'd1);
        applyStart();
        checkOutput("empty_halted", 32'(halted), 32'd1);
        checkOutput("empty_steps", 32'(steps), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("empty_no_valid", 32'(frac_valid), 32'd0);
            @(negedge clk);
        end

        // Start and load in the same IDLE cycle use the freshly written byte
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        prog[0] = 8'h5A;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        start      = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
        buildExpected(1, -1, 0, exp_pc, exp_steps);
        applyCore(-1, 0, timed_out);
        checkHalt("same_cycle", exp_pc, exp_steps);

        // Stall in RUN with spurious results
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        for (int i = 0; i < 3; i++) applyLoad(prog[i]);
        buildExpected(3, -1, 0, exp_pc, exp_steps);
        applyStart();
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1;
            res_hit   = 1'b1;
            checkOutput("stall_valid", 32'(frac_valid), 32'd1);
            checkOutput("stall_data", 32'(frac_data), 32'h11);
            checkOutput("stall_pc", 32'(pc), 32'd0);
            @(negedge clk);
        end
        res_valid = 1'b0;
        res_hit   = 1'b0;
        applyCore(-1, 0, timed_out);
        checkHalt("stall", exp_pc, exp_steps);

        // Reset asserted while in WAIT acts without a clock edge
        applyStart();
        frac_ready = 1'b1;
        @(negedge clk);
        frac_ready = 1'b0;
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_halted", 32'(halted), 32'd0);
        checkOutput("mid_valid", 32'(frac_valid), 32'd0);
        checkOutput("mid_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStart();
        checkOutput("mid_then_halted", 32'(halted), 32'd1);
        checkOutput("mid_then_steps", 32'(steps), 32'd0);
        checkOutput("mid_then_valid", 32'(frac_valid), 32'd0);

        // Fill all 16 entries, then offer a 17th byte
        applyReset();
        for (int i = 0; i < 16; i++) begin
            prog[i] = 8'($urandom_range(0, 255));
            checkOutput("fill_ready", 32'(load_ready), 32'd1);
            applyLoad(prog[i]);
        end
        checkOutput("full_ready", 32'(load_ready), 32'd0);
        applyLoad(~prog[0]);
        checkOutput("full_ready_after", 32'(load_ready), 32'd0);
        buildExpected(16, 7, 1, exp_pc, exp_steps);
        applyStart();
        applyCore(7, 1, timed_out);
        checkHalt("full", exp_pc, exp_steps);

        // Global enable low blocks the load handshake
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ena = 1'b0;
        #1;
        checkOutput("ena_low_ready", 32'(load_ready), 32'd0);
        ena = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fractran_prog_seq.md
# fractran_prog_seq

Program sequencer directly upstream of the FRACTRAN core. It stores a FRACTRAN program (one 8-bit encoded fraction per entry) loaded over a byte handshake. It then presents fractions to the core one at a time and applies FRACTRAN control flow: restart at fraction 0 after any applied fraction, advance on a miss, and halt when a full pass applies nothing. Fraction bytes are opaque here; the core alone interprets them.

## Interface
- DEPTH, 16: program entries; power of two, at least 2.
- STEPW, 16: width of the applied-fraction step counter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  global enable; when low, all state holds and no handshake completes.
- clear  in  1  drops the stored program (len:=0); honoured in IDLE/HALT only.
- load_valid  in  1  program byte offered.
- load_data  in  8  encoded fraction.
- load_ready  out  1  high in IDLE when len<DEPTH.
- start  in  1  one-cycle pulse to begin a run from pc=0.
- frac_valid  out  1  fraction presented to core.
- frac_data  out  8  mem[pc].
- frac_ready  in  1  core accepts fraction (transfer = valid&ready).
- res_valid  in  1  core result for the outstanding fraction.
- res_hit  in  1  1 = fraction applied to accumulator, 0 = not integral.
- pc  out  $clog2(DEPTH)  current fraction index.
- steps  out  STEPW  applied fractions this run; saturates at all-ones.
- busy  out  1  high in RUN/WAIT.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, RUN, WAIT, HALT.
- IDLE:
  - load_valid&load_ready writes mem[len] and increments len.
  - Bytes offered while len=DEPTH are dropped; load_ready stays low.
  - start with len=0 goes to HALT with steps=0.
  - start with len>0 sets pc:=0 and steps:=0, then goes to RUN.
- RUN: frac_valid=1 and frac_data=mem[pc]. On frac_ready, go to WAIT.
- WAIT:
  - Exactly one fraction is outstanding; frac_valid=0.
  - res_valid with res_hit=1 increments steps (saturating), sets pc:=0 and returns to RUN.
  - res_valid with res_hit=0 and pc<len-1 increments pc and returns to RUN.
  - res_valid with res_hit=0 and pc=len-1 goes to HALT; pc holds len-1.
- HALT:
  - halted=1; pc and steps hold for readout.
  - start re-runs the stored program with the IDLE start rules.
  - load_valid or clear returns to IDLE. clear sets len:=0; a load_valid writes mem[len].
- clear while busy is ignored. start while busy is ignored.
- load_valid outside IDLE/HALT is ignored.
- res_valid in any state other than WAIT is ignored and counted nowhere.
- Reset values:
  - state=IDLE; len=0; pc=0; steps=0.
  - frac_valid=0; frac_data=0; busy=0; halted=0.
  - load_ready=1 when ena is high.
  - Program memory contents are don't-care.
- Reset mid-run returns to IDLE immediately and the program is lost (len=0).

## Timing
- frac_valid asserts the cycle after the start edge is registered.
- frac_data and pc are registered, and stable while frac_valid is high.
- A result registered in WAIT gives frac_valid in the next cycle. Minimum loop is 2 cycles per fraction with a zero-wait core.
- A result accepted in the cycle frac_ready is seen is not legal. The core latency is at least 1 cycle after the transfer.
- A load write is visible to a start in the following cycle.
- start and load_valid in the same IDLE cycle: the write happens and start uses the new len.
- The steps saturation check uses the pre-increment value.

## Structure
- Shared package fractran_pkg holds:
  - state enum seq_state_t;
  - FRAC_W=8 constant, shared with the core;
  - result encoding constants.
- One sub-module, fractran_prog_mem: DEPTH×8 register file with one write port and one async read port; no reset on contents.
- The sequencer FSM, len/pc/steps counters and handshakes live in fractran_prog_seq.

## Test plan
- Load 3 bytes {0x11,0x22,0x33}, start. Core always misses after 1 cycle. Required: frac_data 0x11,0x22,0x33 in order; then halted=1, pc=2, steps=0.
- Same program. Core hits on pc=1 twice, else misses. Required: sequence 0,1,0,1,0,1,2, then HALT with steps=2.
- Fill DEPTH=16, offer a 17th byte. Required: load_ready=0 after the 16th write; 17th byte dropped; len=16.
- start with an empty program. Required: HALT the next cycle, frac_valid never high, steps=0.
- Hold frac_ready low 5 cycles in RUN. Required: frac_valid and frac_data stable; spurious res_valid ignored.
- Assert rst_n low mid-WAIT. Required: state IDLE, busy=0, len=0 immediately, without waiting for a clock. A following start halts with steps=0.
